// File: rtl/tgl_rx_pkg.sv
// rtl/tgl_rx_pkg.sv - shared types and default widths for the toggle handshake receiver
package tgl_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tgl_rx_state_t;

  localparam int TGL_RX_DW    = 8;
  localparam int TGL_RX_CNT_W = 8;

endpackage

// File: rtl/tgl_sync.sv
// rtl/tgl_sync.sv - multi-flop synchronizer for the request toggle plus change detector
module tgl_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tgl,
  output logic o_sync_out,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // r_prev follows the synchronized level every cycle, so a change is flagged for exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_tgl};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync_out = r_sync[SYNC_STAGES-1];
  assign o_edge     = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/toggle_hs_rx.sv
// rtl/toggle_hs_rx.sv - two-phase handshake receiver presenting words on a valid/ready port
// Define TGLRX_OVRCNT_EN to add the saturating ovr_cnt dropped-word counter.
module toggle_hs_rx
  import tgl_rx_pkg::*;
#(
  parameter int DW          = TGL_RX_DW,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = TGL_RX_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_tgl,
  input  logic [DW-1:0]    req_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             ack_tgl,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovr_err
`ifdef TGLRX_OVRCNT_EN
  ,
  output logic [CNT_W-1:0] ovr_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tgl_rx_state_t    r_state;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic             r_ack_tgl;
  logic [CNT_W-1:0] r_evt_cnt;
  logic             r_ovr_err;
  logic             w_edge;
  logic             w_sync_out_unused;

  tgl_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_tgl     (req_tgl),
    .o_sync_out(w_sync_out_unused),
    .o_edge    (w_edge)
  );

`ifdef TGLRX_OVRCNT_EN
  logic [CNT_W-1:0] r_ovr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr_cnt <= '0;
    end else if (r_state == WAIT && w_edge && r_ovr_cnt != '1) begin
      r_ovr_cnt <= r_ovr_cnt + CNT_ONE;
    end
  end

  assign ovr_cnt = r_ovr_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ack_tgl   <= 1'b0;
      r_evt_cnt   <= '0;
      r_ovr_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_out_data  <= req_data;
            r_out_valid <= 1'b1;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          // A new request before our ack is dropped; the held word is left untouched
          if (w_edge) begin
            r_ovr_err <= 1'b1;
          end
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_ack_tgl   <= ~r_ack_tgl;
            r_evt_cnt   <= r_evt_cnt + CNT_ONE;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign ack_tgl   = r_ack_tgl;
  assign evt_cnt   = r_evt_cnt;
  assign ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb/tb_toggle_hs_rx.sv - self-checking bench for toggle_hs_rx with a transmitter model
module tb_toggle_hs_rx;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_tgl = 1'b0;
  logic [7:0] a_data = '0;
  logic       a_ready = 1'b0;
  logic       a_valid;
  logic [7:0] a_out;
  logic       a_ack;
  logic [7:0] a_cnt;
  logic       a_ovr;

  logic       b_tgl = 1'b0;
  logic [7:0] b_data = '0;
  logic       b_ready = 1'b0;
  logic       b_valid;
  logic [7:0] b_out;
  logic       b_ack;
  logic [3:0] b_cnt;
  logic       b_ovr;

`ifdef TGLRX_OVRCNT_EN
  logic [7:0] a_ovr_cnt;
  logic [3:0] b_ovr_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic exp_ack = 1'b0;

  always #5 clk = ~clk;

  toggle_hs_rx #(.DW(8), .SYNC_STAGES(SYNC), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req_tgl(a_tgl), .req_data(a_data), .out_ready(a_ready),
    .out_valid(a_valid), .out_data(a_out), .ack_tgl(a_ack), .evt_cnt(a_cnt), .ovr_err(a_ovr)
`ifdef TGLRX_OVRCNT_EN
    , .ovr_cnt(a_ovr_cnt)
`endif
  );

  toggle_hs_rx #(.DW(8), .SYNC_STAGES(SYNC), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req_tgl(b_tgl), .req_data(b_data), .out_ready(b_ready),
    .out_valid(b_valid), .out_data(b_out), .ack_tgl(b_ack), .evt_cnt(b_cnt), .ovr_err(b_ovr)
`ifdef TGLRX_OVRCNT_EN
    , .ovr_cnt(b_ovr_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (a_valid !== 1'b0 || a_out !== 8'h00 || a_ack !== 1'b0 || a_cnt !== 8'h00 || a_ovr !== 1'b0) begin
      bad++;
      $display("FAIL reset_a got v=%b d=%h a=%b c=%0d o=%b exp all zero", a_valid, a_out, a_ack, a_cnt, a_ovr);
    end
    total++;
    if (b_valid !== 1'b0 || b_ack !== 1'b0 || b_cnt !== 4'h0 || b_ovr !== 1'b0) begin
      bad++;
      $display("FAIL reset_b got v=%b a=%b c=%0d o=%b exp all zero", b_valid, b_ack, b_cnt, b_ovr);
    end
`ifdef TGLRX_OVRCNT_EN
    total++;
    if (a_ovr_cnt !== 8'h00) begin
      bad++;
      $display("FAIL reset_ovr_cnt got=%0d exp=0", a_ovr_cnt);
    end
`endif
  endtask

  task automatic test_single();
    int lat;
    a_ready = 1'b1;
    a_data  = 8'hA5;
    a_tgl   = ~a_tgl;
    lat = 0;
    while (!a_valid && lat < 10) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL single_latency got=%0d exp=%0d", lat, LAT);
    end
    total++;
    if (a_out !== 8'hA5) begin
      bad++;
      $display("FAIL single_data got=%h exp=a5", a_out);
    end
    tick();
    exp_ack = ~exp_ack;
    exp_cnt++;
    total++;
    if (a_valid !== 1'b0 || a_ack !== exp_ack || a_cnt !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL single_handshake got v=%b a=%b c=%0d exp v=0 a=%b c=%0d", a_valid, a_ack, a_cnt, exp_ack, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0] w;
    w = 8'($urandom);
    a_ready = 1'b0;
    a_data  = w;
    a_tgl   = ~a_tgl;
    lat = 0;
    while (!a_valid && lat < 10) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== LAT || a_out !== w) begin
      bad++;
      $display("FAIL bp_capture got lat=%0d d=%h exp lat=%0d d=%h", lat, a_out, LAT, w);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (a_valid !== 1'b1 || a_out !== w || a_ack !== exp_ack) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h a=%b exp v=1 d=%h a=%b", i, a_valid, a_out, a_ack, w, exp_ack);
      end
    end
    a_ready = 1'b1;
    tick();
    exp_ack = ~exp_ack;
    exp_cnt++;
    total++;
    if (a_valid !== 1'b0 || a_ack !== exp_ack || a_cnt !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL bp_release got v=%b a=%b c=%0d exp v=0 a=%b c=%0d", a_valid, a_ack, a_cnt, exp_ack, exp_cnt);
    end
  endtask

  task automatic test_random_words();
    int lat;
    int d;
    logic [7:0] w;
    for (int n = 0; n < 12; n++) begin
      d = $urandom_range(0, 4);
      w = 8'($urandom);
      a_ready = (d == 0);
      a_data  = w;
      a_tgl   = ~a_tgl;
      lat = 0;
      while (!a_valid && lat < 10) begin
        tick();
        lat++;
      end
      total++;
      if (lat !== LAT || a_out !== w) begin
        bad++;
        $display("FAIL rand_capture n=%0d got lat=%0d d=%h exp lat=%0d d=%h", n, lat, a_out, LAT, w);
      end
      for (int j = 0; j < d; j++) begin
        tick();
        total++;
        if (a_valid !== 1'b1 || a_out !== w || a_ack !== exp_ack) begin
          bad++;
          $display("FAIL rand_hold n=%0d got v=%b d=%h a=%b exp v=1 d=%h a=%b", n, a_valid, a_out, a_ack, w, exp_ack);
        end
      end
      a_ready = 1'b1;
      tick();
      exp_ack = ~exp_ack;
      exp_cnt++;
      total++;
      if (a_valid !== 1'b0 || a_ack !== exp_ack || a_cnt !== 8'(exp_cnt)) begin
        bad++;
        $display("FAIL rand_handshake n=%0d got v=%b a=%b c=%0d exp v=0 a=%b c=%0d", n, a_valid, a_ack, a_cnt, exp_ack, exp_cnt);
      end
      a_ready = 1'b0;
    end
  endtask

  task automatic test_overrun();
    int lat;
    a_ready = 1'b0;
    a_data  = 8'h3C;
    a_tgl   = ~a_tgl;
    lat = 0;
    while (!a_valid && lat < 10) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== LAT || a_ovr !== 1'b0) begin
      bad++;
      $display("FAIL ovr_first got lat=%0d o=%b exp lat=%0d o=0", lat, a_ovr, LAT);
    end
    a_data = 8'hC3;
    a_tgl  = ~a_tgl;
    for (int i = 0; i < LAT + 1; i++) tick();
    total++;
    if (a_ovr !== 1'b1 || a_valid !== 1'b1 || a_out !== 8'h3C || a_ack !== exp_ack) begin
      bad++;
      $display("FAIL ovr_flag got o=%b v=%b d=%h a=%b exp o=1 v=1 d=3c a=%b", a_ovr, a_valid, a_out, a_ack, exp_ack);
    end
`ifdef TGLRX_OVRCNT_EN
    total++;
    if (a_ovr_cnt !== 8'd1) begin
      bad++;
      $display("FAIL ovr_cnt got=%0d exp=1", a_ovr_cnt);
    end
`endif
    a_ready = 1'b1;
    tick();
    exp_ack = ~exp_ack;
    exp_cnt++;
    total++;
    if (a_valid !== 1'b0 || a_ack !== exp_ack || a_cnt !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL ovr_release got v=%b a=%b c=%0d exp v=0 a=%b c=%0d", a_valid, a_ack, a_cnt, exp_ack, exp_cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (a_valid !== 1'b0 || a_ack !== exp_ack || a_ovr !== 1'b1) begin
      bad++;
      $display("FAIL ovr_no_extra got v=%b a=%b o=%b exp v=0 a=%b o=1", a_valid, a_ack, a_ovr, exp_ack);
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic b_exp_ack;
    b_exp_ack = 1'b0;
    b_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      b_data = 8'(i);
      b_tgl  = ~b_tgl;
      lat = 0;
      while (!b_valid && lat < 10) begin
        tick();
        lat++;
      end
      total++;
      if (lat !== LAT || b_out !== 8'(i)) begin
        bad++;
        $display("FAIL wrap_data i=%0d got lat=%0d d=%h exp lat=%0d d=%h", i, lat, b_out, LAT, 8'(i));
      end
      tick();
      b_exp_ack = ~b_exp_ack;
      total++;
      if (b_valid !== 1'b0 || b_ack !== b_exp_ack || b_cnt !== 4'((i + 1) % 16)) begin
        bad++;
        $display("FAIL wrap_hs i=%0d got v=%b a=%b c=%0d exp v=0 a=%b c=%0d", i, b_valid, b_ack, b_cnt, b_exp_ack, (i + 1) % 16);
      end
    end
    total++;
    if (b_cnt !== 4'd1 || b_ovr !== 1'b0) begin
      bad++;
      $display("FAIL wrap_final got c=%0d o=%b exp c=1 o=0", b_cnt, b_ovr);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    a_ready = 1'b0;
    a_data  = 8'h77;
    a_tgl   = ~a_tgl;
    lat = 0;
    while (!a_valid && lat < 10) begin
      tick();
      lat++;
    end
    total++;
    if (a_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_enter_wait got v=%b exp v=1", a_valid);
    end
    rst   = 1'b1;
    a_tgl = 1'b0;
    b_tgl = 1'b0;
    tick();
    rst = 1'b0;
    exp_ack = 1'b0;
    exp_cnt = 0;
    total++;
    if (a_valid !== 1'b0 || a_ack !== 1'b0 || a_cnt !== 8'h00 || a_ovr !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got v=%b a=%b c=%0d o=%b exp all zero", a_valid, a_ack, a_cnt, a_ovr);
    end
`ifdef TGLRX_OVRCNT_EN
    total++;
    if (a_ovr_cnt !== 8'h00) begin
      bad++;
      $display("FAIL mid_ovr_cnt got=%0d exp=0", a_ovr_cnt);
    end
`endif
    for (int i = 0; i < 3; i++) tick();
    a_ready = 1'b1;
    a_data  = 8'h5A;
    a_tgl   = 1'b1;
    lat = 0;
    while (!a_valid && lat < 10) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== LAT || a_out !== 8'h5A) begin
      bad++;
      $display("FAIL mid_restart got lat=%0d d=%h exp lat=%0d d=5a", lat, a_out, LAT);
    end
    tick();
    total++;
    if (a_valid !== 1'b0 || a_ack !== 1'b1 || a_cnt !== 8'd1) begin
      bad++;
      $display("FAIL mid_restart_hs got v=%b a=%b c=%0d exp v=0 a=1 c=1", a_valid, a_ack, a_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_random_words();
    test_overrun();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
